// File: rtl/result_collector_pkg.sv
// rtl/result_collector_pkg.sv - shared widths, limits and sizing helper for the result collector
package result_collector_pkg;

    localparam int RESULT_WIDTH    = 33;
    localparam int CARRY_CNT_WIDTH = 16;
    localparam logic [CARRY_CNT_WIDTH-1:0] CARRY_CNT_MAX = 16'hFFFF;

    // Occupancy needs one bit more than the pointers so that "full" (== DEPTH)
    // is distinguishable from "empty" (== 0).
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/result_fifo_mem.sv
// rtl/result_fifo_mem.sv - DEPTH x DATA_W register array, one write port, async read port
//
// Ports:
//   clock    in   rising-edge clock
//   wr_en    in   write strobe
//   wr_addr  in   write index
//   wr_data  in   write data
//   rd_addr  in   read index
//   rd_data  out  combinational read of entry rd_addr
//
// Contents are deliberately not reset; occupancy tracking in the parent
// guarantees a location is written before it is ever presented as valid.
module result_fifo_mem #(
    parameter int DATA_W = 33,
    parameter int DEPTH  = 4
) (
    input  logic                     clock,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [DATA_W-1:0]        rd_data
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/result_collector.sv
// rtl/result_collector.sv - buffers caller results in a FIFO and counts carry-set results
//
// Optional feature macro: RESULT_COLLECTOR_PARITY_EN (adds stored even parity
// per entry and the io_out_parity output).
//
// Ports:
//   clock, reset    single clock, synchronous active-high reset
//   io_in_*         producer side valid/ready/bits
//   io_out_*        consumer side valid/ready/bits (head of FIFO)
//   io_count        current occupancy, 0..DEPTH
//   io_clear        zeroes io_carryCount (wins over a same-cycle increment)
//   io_carryCount   saturating count of accepted results with bit WIDTH-1 set
//   io_out_parity   (macro only) stored parity of head entry, gated by io_out_valid
module result_collector
    import result_collector_pkg::*;
#(
    parameter int WIDTH = RESULT_WIDTH,
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       io_in_valid,
    output logic                       io_in_ready,
    input  logic [WIDTH-1:0]           io_in_bits,
    output logic                       io_out_valid,
    input  logic                       io_out_ready,
    output logic [WIDTH-1:0]           io_out_bits,
    output logic [cnt_width(DEPTH)-1:0] io_count,
    input  logic                       io_clear,
    output logic [CARRY_CNT_WIDTH-1:0] io_carryCount
`ifdef RESULT_COLLECTOR_PARITY_EN
    ,
    output logic                       io_out_parity
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = cnt_width(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

`ifdef RESULT_COLLECTOR_PARITY_EN
    localparam int ENTRY_W = WIDTH + 1;
`else
    localparam int ENTRY_W = WIDTH;
`endif

    logic [PTR_W-1:0]           wr_ptr_q;
    logic [PTR_W-1:0]           rd_ptr_q;
    logic [CNT_W-1:0]           count_q;
    logic [CARRY_CNT_WIDTH-1:0] carry_q;

    logic               push;
    logic               pop;
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] rd_entry;

    // Ready/valid come only from the occupancy register, so a full FIFO
    // refuses a push even when the consumer pops in the same cycle.
    assign io_in_ready  = (count_q != FULL_CNT);
    assign io_out_valid = (count_q != '0);
    assign push         = io_in_valid && io_in_ready;
    assign pop          = io_out_valid && io_out_ready;

    // Pointer and occupancy tracking. Pointers are exactly log2(DEPTH) bits
    // so they wrap from DEPTH-1 to 0 without explicit compare.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Carry counter: clear has priority, then saturating increment on a
    // pushed result whose top bit is set. Pops never touch it.
    always_ff @(posedge clock) begin
        if (reset) begin
            carry_q <= '0;
        end else if (io_clear) begin
            carry_q <= '0;
        end else if (push && io_in_bits[WIDTH-1] && (carry_q != CARRY_CNT_MAX)) begin
            carry_q <= carry_q + CARRY_CNT_WIDTH'(1);
        end
    end

`ifdef RESULT_COLLECTOR_PARITY_EN
    assign wr_entry = {^io_in_bits, io_in_bits};
`else
    assign wr_entry = io_in_bits;
`endif

    result_fifo_mem #(
        .DATA_W (ENTRY_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clock   (clock),
        .wr_en   (push),
        .wr_addr (wr_ptr_q),
        .wr_data (wr_entry),
        .rd_addr (rd_ptr_q),
        .rd_data (rd_entry)
    );

    assign io_out_bits   = rd_entry[WIDTH-1:0];
    assign io_count      = count_q;
    assign io_carryCount = carry_q;

`ifdef RESULT_COLLECTOR_PARITY_EN
    assign io_out_parity = io_out_valid & rd_entry[WIDTH];
`endif

endmodule

// File: tb/tb_result_collector.sv
// tb/tb_result_collector.sv - self-checking bench for result_collector against a queue model
module tb_result_collector;

    localparam int W     = 33;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          io_in_valid = 1'b0;
    logic          io_in_ready;
    logic [W-1:0]  io_in_bits = '0;
    logic          io_out_valid;
    logic          io_out_ready = 1'b0;
    logic [W-1:0]  io_out_bits;
    logic [CW-1:0] io_count;
    logic          io_clear = 1'b0;
    logic [15:0]   io_carryCount;
`ifdef RESULT_COLLECTOR_PARITY_EN
    logic          io_out_parity;
`endif

    result_collector #(.WIDTH(W), .DEPTH(DEPTH)) dut (
        .clock         (clock),
        .reset         (reset),
        .io_in_valid   (io_in_valid),
        .io_in_ready   (io_in_ready),
        .io_in_bits    (io_in_bits),
        .io_out_valid  (io_out_valid),
        .io_out_ready  (io_out_ready),
        .io_out_bits   (io_out_bits),
        .io_count      (io_count),
        .io_clear      (io_clear),
        .io_carryCount (io_carryCount)
`ifdef RESULT_COLLECTOR_PARITY_EN
        ,
        .io_out_parity (io_out_parity)
`endif
    );

    always #5 clock = ~clock;

    int n_total = 0;
    int n_pass  = 0;
    bit chk_en  = 1'b0;

    // Reference model: a plain queue of accepted results plus an integer counter.
    logic [W-1:0] mq[$];
    int           m_carry = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    always @(posedge clock) begin : model
        bit do_push;
        bit do_pop;
        if (reset) begin
            mq.delete();
            m_carry = 0;
        end else begin
            do_push = io_in_valid && (mq.size() < DEPTH);
            do_pop  = io_out_ready && (mq.size() > 0);
            if (io_clear) m_carry = 0;
            else if (do_push && io_in_bits[W-1] && m_carry < 65535) m_carry = m_carry + 1;
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back(io_in_bits);
        end
    end

    always @(negedge clock) begin : compare
        if (chk_en) begin
            check("in_ready",   64'(io_in_ready),   64'(mq.size() != DEPTH));
            check("out_valid",  64'(io_out_valid),  64'(mq.size() != 0));
            check("count",      64'(io_count),      64'(mq.size()));
            check("carryCount", 64'(io_carryCount), 64'(m_carry));
            if (mq.size() != 0) begin
                check("out_bits", 64'(io_out_bits), 64'(mq[0]));
`ifdef RESULT_COLLECTOR_PARITY_EN
                check("out_parity", 64'(io_out_parity), 64'(^mq[0]));
`endif
            end
        end
    end

    // Drive one cycle of inputs, then land 1 time unit after the active edge.
    task automatic cyc(input bit v, input logic [W-1:0] b, input bit r, input bit c, input bit rst);
        io_in_valid  = v;
        io_in_bits   = b;
        io_out_ready = r;
        io_clear     = c;
        reset        = rst;
        @(posedge clock);
        #1;
    endtask

    logic [W-1:0] fill_vals [4];

    initial begin
        fill_vals[0] = 33'h0_0000_0001;
        fill_vals[1] = 33'h1_0000_0002;
        fill_vals[2] = 33'h0_0000_0003;
        fill_vals[3] = 33'h1_FFFF_FFFF;

        cyc(0, '0, 0, 0, 1);
        cyc(0, '0, 0, 0, 1);
        chk_en = 1'b1;
        cyc(0, '0, 0, 0, 0);
        check("rst_in_ready",  64'(io_in_ready),   64'd1);
        check("rst_out_valid", 64'(io_out_valid),  64'd0);
        check("rst_count",     64'(io_count),      64'd0);
        check("rst_carry",     64'(io_carryCount), 64'd0);

        // Fill with consumer stalled; fifth push must be refused.
        for (int i = 0; i < 4; i++) cyc(1, fill_vals[i], 0, 0, 0);
        check("fill_count",    64'(io_count),      64'd4);
        check("fill_in_ready", 64'(io_in_ready),   64'd0);
        check("fill_carry",    64'(io_carryCount), 64'd2);
        cyc(1, 33'h1_0000_0055, 0, 0, 0);
        cyc(1, 33'h1_0000_0055, 1, 0, 0);
        // The held fifth push was refused even while a pop occurred.
        check("full_no_push_cnt",   64'(io_count),      64'd3);
        check("full_no_push_carry", 64'(io_carryCount), 64'd2);
        check("full_head",          64'(io_out_bits),   64'(fill_vals[1]));
        cyc(0, '0, 0, 0, 1);

        for (int i = 0; i < 4; i++) cyc(1, fill_vals[i], 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            check("drain_bits",  64'(io_out_bits), 64'(fill_vals[i]));
            check("drain_count", 64'(io_count),    64'(4 - i));
            cyc(0, '0, 1, 0, 0);
        end
        check("drain_empty", 64'(io_out_valid), 64'd0);

        // Streaming: count held at 1, pointers wrap twice.
        cyc(1, 33'h0_0000_0100, 1, 0, 0);
        for (int i = 1; i < 10; i++) begin
            check("stream_count", 64'(io_count), 64'd1);
            check("stream_bits",  64'(io_out_bits), 64'(33'h0_0000_0100 + 33'(i - 1)));
            cyc(1, 33'h0_0000_0100 + 33'(i), 1, 0, 0);
        end
        cyc(0, '0, 1, 0, 0);
        check("stream_end", 64'(io_count), 64'd0);

        // Randomized phase with occasional clears and resets.
        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(0, 2) != 0), {1'($urandom()), 32'($urandom())},
                1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 15) == 0),
                1'($urandom_range(0, 63) == 0));
        end

        // Reset with three entries buffered and a live handshake.
        cyc(0, '0, 0, 1, 1);
        for (int i = 0; i < 3; i++) cyc(1, 33'h1_0000_0000 + 33'(i), 0, 0, 0);
        check("pre_rst_count", 64'(io_count), 64'd3);
        cyc(1, 33'h1_2345_6789, 1, 0, 1);
        check("mid_rst_count", 64'(io_count),      64'd0);
        check("mid_rst_valid", 64'(io_out_valid),  64'd0);
        check("mid_rst_carry", 64'(io_carryCount), 64'd0);

`ifdef RESULT_COLLECTOR_PARITY_EN
        cyc(1, 33'h0_0000_0007, 0, 0, 0);
        check("parity_7", 64'(io_out_parity), 64'd1);
        cyc(0, '0, 1, 0, 0);
`endif

        // Carry saturation: preload to 0xFFFE, two more saturate at 0xFFFF.
        cyc(0, '0, 0, 1, 0);
        for (int i = 0; i < 65534; i++) cyc(1, {1'b1, 32'($urandom())}, 1, 0, 0);
        check("carry_fffe", 64'(io_carryCount), 64'hFFFE);
        cyc(1, 33'h1_0000_0000, 1, 0, 0);
        cyc(1, 33'h1_0000_0001, 1, 0, 0);
        check("carry_sat", 64'(io_carryCount), 64'hFFFF);
        cyc(1, 33'h1_0000_0002, 1, 0, 0);
        check("carry_hold", 64'(io_carryCount), 64'hFFFF);
        cyc(1, 33'h1_0000_0003, 1, 1, 0);
        check("carry_clear", 64'(io_carryCount), 64'd0);
        cyc(1, 33'h1_0000_0004, 1, 0, 0);
        check("carry_after_clear", 64'(io_carryCount), 64'd1);
        cyc(0, '0, 1, 0, 0);
        cyc(0, '0, 1, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/result_collector.md
# result_collector

Downstream stage for the XOR-blackbox caller. It accepts each 33-bit `io_valOut` result over a valid/ready handshake and buffers it in a DEPTH-entry FIFO, so a stalled consumer never loses results. It also keeps a saturating count of results with the carry/top bit (bit 32) set. It sits between the caller's output and the result-consuming logic.

## Interface
Parameters:
- `WIDTH`, 33: result width; bit WIDTH-1 is the carry bit.
- `DEPTH`, 4: FIFO entries; must be a power of two and ≥ 2.

Ports:
- `clock`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `io_in_valid`  in  1: producer presents a result.
- `io_in_ready`  out  1: collector can accept.
- `io_in_bits`  in  WIDTH: result from the caller.
- `io_out_valid`  out  1: head entry available.
- `io_out_ready`  in  1: consumer takes the head.
- `io_out_bits`  out  WIDTH: head entry.
- `io_count`  out  log2(DEPTH)+1: current occupancy.
- `io_clear`  in  1: clears `io_carryCount` only.
- `io_carryCount`  out  16: saturating count of accepted results with bit WIDTH-1 = 1.

## Operation
- Push when `io_in_valid && io_in_ready`; pop when `io_out_valid && io_out_ready`.
- `io_in_ready = (io_count != DEPTH)`. A full FIFO does not accept, even if a pop happens in the same cycle.
- `io_out_valid = (io_count != 0)`. There is no combinational input-to-output bypass.
- `io_out_bits` is the entry at the read pointer. Its value is don't-care when empty, but the bench expects it to be stable while `io_out_valid && !io_out_ready`.
- Push and pop in the same cycle (0 < count < DEPTH): both pointers advance and the count is unchanged.
- Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- `io_carryCount` rules:
  - Increments on a push whose `io_in_bits[WIDTH-1]` is 1.
  - Saturates at 0xFFFF.
  - `io_clear` wins over a same-cycle increment, so the result is 0.
  - Not affected by pops.
- Reset:
  - Pointers and count go to 0; `io_carryCount` goes to 0.
  - Outputs after reset: `io_in_ready`=1, `io_out_valid`=0, `io_count`=0, `io_carryCount`=0.
  - Storage contents are not reset.
  - Reset mid-operation discards all buffered entries; any handshake in the reset cycle is ignored.

## Timing
- Latency is 1 cycle: data pushed at edge N is on `io_out_bits` with `io_out_valid`=1 after edge N.
- `io_in_ready`, `io_out_valid`, `io_count` and `io_carryCount` are register-derived. None combinationally depend on `io_in_valid` or `io_out_ready`.
- Sustained throughput is 1 result/cycle when the consumer is always ready.

## Configuration
- Macro: `RESULT_COLLECTOR_PARITY_EN`.
- Defined:
  - Each entry stores an extra even-parity bit, computed at push as the XOR of `io_in_bits`.
  - Extra output `io_out_parity` (out, 1) reflects the head entry's stored parity. Reset value is don't-care; it is gated by `io_out_valid`.
- Undefined: no parity storage and no `io_out_parity` port. All other behaviour is identical.

## Structure
- Shared package `result_collector_pkg`:
  - `RESULT_WIDTH` = 33.
  - `CARRY_CNT_WIDTH` = 16.
  - `CARRY_CNT_MAX` = 16'hFFFF.
  - Count-width helper clog2(DEPTH)+1.
- One sub-module, `result_fifo_mem`: DEPTH×(WIDTH[+1]) register array with write port (enable, address, data) and asynchronous read port.
- Pointers, count, handshake and carry counter live in `result_collector`.

## Test plan
- Reset then idle → `io_in_ready`=1, `io_out_valid`=0, `io_count`=0, `io_carryCount`=0.
- Fill with `io_out_ready`=0: push 0x0_0000_0001, 0x1_0000_0002, 0x0_0000_0003, 0x1_FFFF_FFFF → `io_count`=4, `io_in_ready`=0, `io_carryCount`=2. A fifth push with valid held is not accepted.
- Drain full FIFO with `io_out_ready`=1 → `io_out_bits` shows the values above in order, one per cycle. `io_count` steps 4,3,2,1,0, then `io_out_valid`=0.
- Continuous stream of 10 values with both sides ready and count 1 → one pop per cycle, order preserved, pointers wrap twice, no stall.
- Carry counter:
  - Preload to 0xFFFE via pushes with bit 32 set, then two more → saturates at 0xFFFF.
  - `io_clear`=1 together with a carry push → 0.
- Reset asserted with `io_count`=3 → next cycle `io_count`=0 and `io_out_valid`=0. With `RESULT_COLLECTOR_PARITY_EN` defined, a push of 0x0_0000_0007 gives `io_out_parity`=1.
